keypad_scan: RTL and testbench

//   Input-side counterpart of the score/7-seg display path. Drives a 4x4 matrix keypad
//   row by row (active-low) and samples its columns. Debounces whole-matrix scan frames.

---
 rtl/keypad_scan_if.sv | 27 ++
 rtl/keypad_scan.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_scan.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// Keypad-side bundle: physical row/column lines plus the decoded key event outputs.
interface keypad_scan_if;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       key_release;

  modport master (
    input  col_in,
    output row_out,
    output key_code,
    output key_valid,
    output key_down,
    output key_release
  );

  modport slave (
    output col_in,
    input  row_out,
    input  key_code,
    input  key_valid,
    input  key_down,
    input  key_release
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: active-low row drive, column synchroniser, frame-level
// debounce and a press/release event FSM feeding the game control logic.
module keypad_scan #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kp
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [4:0]       RES_NONE = 5'b0_0000;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;

  // Number of pulled-low (pressed) columns in one row sample.
  function automatic logic [2:0] count_lows(input logic [3:0] col);
    count_lows = 3'd0;
    for (int i = 0; i < 4; i++) begin
      count_lows = count_lows + {2'b00, ~col[i]};
    end
  endfunction

  // Index of the lowest pulled-low column; only meaningful when exactly one is low.
  function automatic logic [1:0] low_index(input logic [3:0] col);
    low_index = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col[i]) begin
        low_index = 2'(i);
      end
    end
  endfunction

  logic [3:0]       col_meta_r;
  logic [3:0]       col_sync_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic             tick_s;
  logic             frame_end_s;
  logic [1:0]       row_idx_r;
  logic [3:0]       row_out_r;
  logic [1:0]       hits_r;
  logic [3:0]       hit_code_r;
  logic [2:0]       row_lows_s;
  logic [2:0]       hits_sum_s;
  logic [1:0]       hits_next_s;
  logic [3:0]       code_next_s;
  logic [4:0]       frame_res_s;
  logic [4:0]       last_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [4:0]       stable_r;
  state_t           state_r;
  state_t           state_next_s;
  logic [3:0]       key_code_r;
  logic [3:0]       key_code_next_s;
  logic             key_valid_r;
  logic             key_valid_next_s;
  logic             key_down_r;
  logic             key_down_next_s;
  logic             key_release_r;
  logic             key_release_next_s;

  assign tick_s      = (div_cnt_r == DIV_LAST);
  assign frame_end_s = tick_s && (row_idx_r == 2'd3);

  // Two-flop synchroniser for the asynchronous column lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_r <= 4'hF;
      col_sync_r <= 4'hF;
    end else begin
      col_meta_r <= kp.col_in;
      col_sync_r <= col_meta_r;
    end
  end

  // Row-period divider and the row drive rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= '0;
      row_idx_r <= 2'd0;
      row_out_r <= 4'b1110;
    end else if (tick_s) begin
      div_cnt_r <= '0;
      row_idx_r <= row_idx_r + 2'd1;
      row_out_r <= {row_out_r[2:0], row_out_r[3]};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Fold the current row sample into the frame; hits saturates at 2 (ghost/multi-key).
  always_comb begin
    row_lows_s  = count_lows(col_sync_r);
    hits_sum_s  = {1'b0, hits_r} + row_lows_s;
    hits_next_s = (hits_sum_s >= 3'd2) ? 2'd2 : hits_sum_s[1:0];
    if (row_lows_s == 3'd1) begin
      code_next_s = {row_idx_r, low_index(col_sync_r)};
    end else begin
      code_next_s = hit_code_r;
    end
    if (hits_next_s == 2'd1) begin
      frame_res_s = {1'b1, code_next_s};
    end else begin
      frame_res_s = RES_NONE;
    end
    if (frame_res_s == last_r) begin
      cnt_next_s = (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = CNT_W'(1);
    end
  end

  // Frame accumulator and debounce state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_r     <= 2'd0;
      hit_code_r <= 4'd0;
      last_r     <= RES_NONE;
      cnt_r      <= '0;
      stable_r   <= RES_NONE;
    end else if (frame_end_s) begin
      hits_r     <= 2'd0;
      hit_code_r <= 4'd0;
      last_r     <= frame_res_s;
      cnt_r      <= cnt_next_s;
      if (cnt_next_s == CNT_MAX) begin
        stable_r <= frame_res_s;
      end
    end else if (tick_s) begin
      hits_r     <= hits_next_s;
      hit_code_r <= code_next_s;
    end
  end

  // Event FSM: next state and next output values from the debounced result.
  always_comb begin
    state_next_s       = state_r;
    key_code_next_s    = key_code_r;
    key_down_next_s    = key_down_r;
    key_valid_next_s   = 1'b0;
    key_release_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (stable_r[4]) begin
          state_next_s     = ST_PRESSED;
          key_code_next_s  = stable_r[3:0];
          key_down_next_s  = 1'b1;
          key_valid_next_s = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (!stable_r[4]) begin
          state_next_s       = ST_IDLE;
          key_down_next_s    = 1'b0;
          key_release_next_s = 1'b1;
        end else if (stable_r[3:0] != key_code_r) begin
          key_code_next_s  = stable_r[3:0];
          key_valid_next_s = 1'b1;
        end else begin
          state_next_s = ST_PRESSED;
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        key_down_next_s = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      key_code_r    <= 4'd0;
      key_valid_r   <= 1'b0;
      key_down_r    <= 1'b0;
      key_release_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      key_code_r    <= key_code_next_s;
      key_valid_r   <= key_valid_next_s;
      key_down_r    <= key_down_next_s;
      key_release_r <= key_release_next_s;
    end
  end

  assign kp.row_out     = row_out_r;
  assign kp.key_code    = key_code_r;
  assign kp.key_valid   = key_valid_r;
  assign kp.key_down    = key_down_r;
  assign kp.key_release = key_release_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a matrix keypad model drives col_in, expected
// press/release events are queued with the stimulus and matched as the DUT emits them.
module tb_keypad_scan;

  logic        clk;
  logic        rst;
  logic [15:0] keys;
  int          n_checks;
  int          n_fail;
  logic [7:0]  exp_q[$];

  keypad_scan_if bus ();

  keypad_scan #(
    .CLK_HZ        (400),
    .SCAN_HZ       (100),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a column reads low only where a pressed key meets a driven row.
  always_comb begin
    bus.col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!bus.row_out[r] && keys[r*4+c]) begin
          bus.col_in[c] = 1'b0;
        end
      end
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected event word: {0, release, valid, key_down, key_code}.
  task automatic push_event(input logic is_release, input logic [3:0] code);
    exp_q.push_back({1'b0, is_release, ~is_release, ~is_release, code});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 67 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    @(posedge clk);
    check_value(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value(tag, {bus.row_out, bus.key_code, bus.key_valid, bus.key_down, bus.key_release},
                {4'b1110, 4'h0, 3'b000});
  endtask

  // Monitor: every emitted pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (bus.key_valid || bus.key_release) begin
      if (exp_q.size() == 0) begin
        check_value("spurious_event",
                    {1'b0, bus.key_release, bus.key_valid, bus.key_down, bus.key_code}, 8'h00);
      end else begin
        check_value("event",
                    {1'b0, bus.key_release, bus.key_valid, bus.key_down, bus.key_code},
                    exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    keys     = 16'h0000;
    rst      = 1'b1;
    #2;
    check_reset_outputs("reset_initial");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-cycle after the rows have moved on.
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_value("row_rot1", bus.row_out, 4'b1101);
    repeat (4) @(posedge clk);
    #1 check_value("row_rot2", bus.row_out, 4'b1011);
    repeat (4) @(posedge clk);
    #1 check_value("row_rot3", bus.row_out, 4'b0111);
    repeat (4) @(posedge clk);
    #1 check_value("row_rot4", bus.row_out, 4'b1110);

    // Hold (2,1): one press event, then silence.
    @(negedge clk);
    keys = 16'h0200;
    push_event(1'b0, 4'd9);
    drain("press_9");
    repeat (500) @(posedge clk);

    // Release: one release event, code held.
    @(negedge clk);
    keys = 16'h0000;
    push_event(1'b1, 4'd9);
    drain("release_9");
    #1 check_value("code_held", bus.key_code, 4'd9);
    repeat (100) @(posedge clk);

    // Short toggles are filtered; the final hold is accepted once.
    @(negedge clk);
    keys = 16'h0200;
    repeat (16) @(posedge clk);
    @(negedge clk);
    keys = 16'h0000;
    repeat (16) @(posedge clk);
    @(negedge clk);
    keys = 16'h0200;
    push_event(1'b0, 4'd9);
    drain("toggle_press_9");
    repeat (100) @(posedge clk);
    @(negedge clk);
    keys = 16'h0000;
    push_event(1'b1, 4'd9);
    drain("toggle_release_9");
    repeat (80) @(posedge clk);

    // Two keys together from idle give nothing.
    @(negedge clk);
    keys = 16'h8001;
    repeat (200) @(posedge clk);
    @(negedge clk);
    keys = 16'h0000;
    repeat (80) @(posedge clk);
    #1 check_value("ghost_idle", {bus.key_down, bus.key_code}, 5'h09);

    // Hold (1,2), then add (3,0): press 6 then release 6.
    @(negedge clk);
    keys = 16'h0040;
    push_event(1'b0, 4'd6);
    drain("press_6");
    @(negedge clk);
    keys = 16'h1040;
    push_event(1'b1, 4'd6);
    drain("multi_release_6");
    @(negedge clk);
    keys = 16'h0000;
    repeat (80) @(posedge clk);

    // Reset pulse while (1,2) is held: outputs clear, fresh press, no release.
    @(negedge clk);
    keys = 16'h0040;
    push_event(1'b0, 4'd6);
    drain("press_6_pre_reset");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_held");
    @(posedge clk);
    #3;
    rst = 1'b0;
    push_event(1'b0, 4'd6);
    drain("press_6_post_reset");
    repeat (150) @(posedge clk);
    #1 check_value("held_after_reset", {bus.key_down, bus.key_code}, 5'h16);
    @(negedge clk);
    keys = 16'h0000;
    push_event(1'b1, 4'd6);
    drain("release_6_final");
    repeat (20) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
